// File: rtl/qnet_frame_swctl.sv
// qnet_frame_swctl: frame-synchronous sequencer for the fast optical switch
// control (sw_ctl) and the scope trigger (trig_out). Each frame starts on a
// DAC-transfer go pulse. The switch window and the trigger pulse are placed
// relative to the in-frame cycle counter. The block counts frames and stops
// after a programmed number of frames, or runs until abort when that number is 0.
module qnet_frame_swctl #(
  parameter int CNT_W     = 16,
  parameter int FRM_W     = 16,
  parameter int TRIG_CYCS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             abort,
  input  logic             go,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_sw_dly,
  input  logic [CNT_W-1:0] cfg_sw_len,
  input  logic [FRM_W-1:0] cfg_num_frm,
  output logic             sw_ctl,
  output logic             trig_out,
  output logic             busy,
  output logic [FRM_W-1:0] frm_cnt,
  output logic             done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam logic [CNT_W-1:0] CYC_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] PER_MIN  = CNT_W'(2);
  localparam logic [FRM_W-1:0] FRM_ONE  = FRM_W'(1);
  localparam logic [CNT_W:0]   TRIG_LIM = (CNT_W+1)'(TRIG_CYCS);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cyc, cyc_nxt;
  logic [FRM_W-1:0] frm_nxt;
  logic             done_nxt;
  logic             latch_cfg;

  // Shadow configuration, captured at arm time and frozen for the whole run.
  logic [CNT_W-1:0] per_q;
  logic [CNT_W-1:0] dly_q;
  logic [CNT_W:0]   end_q;    // exclusive end of the switch window
  logic [FRM_W-1:0] num_q;

  // Values captured at arm: period clamped to 2, window end clipped to the frame.
  logic [CNT_W-1:0] per_clamp;
  logic [CNT_W:0]   win_sum;
  logic [CNT_W:0]   win_end;

  logic             run_nxt;
  logic             sw_nxt;
  logic             trig_nxt;
  logic [FRM_W-1:0] frm_inc;
  logic             frame_last;

  // Config pre-processing. The dly+len sum is one bit wider so it cannot wrap.
  always_comb begin
    per_clamp = (cfg_period < PER_MIN) ? PER_MIN : cfg_period;
    win_sum   = {1'b0, cfg_sw_dly} + {1'b0, cfg_sw_len};
    win_end   = (win_sum < {1'b0, per_clamp}) ? win_sum : {1'b0, per_clamp};
  end

  assign frm_inc    = frm_cnt + FRM_ONE;
  assign frame_last = (cyc == (per_q - CYC_ONE));

  // Next-state, cycle counter and frame counter decode.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_nxt = state;
    cyc_nxt   = cyc;
    frm_nxt   = frm_cnt;
    done_nxt  = 1'b0;
    latch_cfg = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arm) begin
          latch_cfg = 1'b1;
          state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (go) begin
          state_nxt = ST_RUN;
          cyc_nxt   = '0;
          frm_nxt   = '0;
        end else if (arm) begin
          latch_cfg = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (frame_last) begin
          cyc_nxt = '0;
          frm_nxt = frm_inc;
          if ((num_q != '0) && (frm_inc == num_q)) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end else begin
          cyc_nxt = cyc + CYC_ONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The outputs are decoded from next-cycle values and then registered.
  // This makes them visible in the same cycle as the cyc value they belong to.
  always_comb begin
    run_nxt  = (state_nxt == ST_RUN);
    sw_nxt   = run_nxt && (cyc_nxt >= dly_q) && ({1'b0, cyc_nxt} < end_q);
    trig_nxt = run_nxt && ({1'b0, cyc_nxt} < TRIG_LIM);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Every register
    // then samples values from before the edge, whatever the statement order.
    if (rst) begin
      state    <= ST_IDLE;
      cyc      <= '0;
      frm_cnt  <= '0;
      sw_ctl   <= 1'b0;
      trig_out <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cyc      <= cyc_nxt;
      frm_cnt  <= frm_nxt;
      sw_ctl   <= sw_nxt;
      trig_out <= trig_nxt;
      busy     <= (state_nxt != ST_IDLE);
      done     <= done_nxt;
    end
  end

  // Shadow configuration registers, loaded only on an accepted arm.
  always_ff @(posedge clk) begin
    // NOTE: the shadow registers are reset on purpose. A reset mid-run must
    // clear the old settings, so no stale window survives into a later run.
    if (rst) begin
      per_q <= PER_MIN;
      dly_q <= '0;
      end_q <= '0;
      num_q <= '0;
    end else if (latch_cfg) begin
      per_q <= per_clamp;
      dly_q <= cfg_sw_dly;
      end_q <= win_end;
      num_q <= cfg_num_frm;
    end
  end

endmodule

// File: tb/tb_qnet_frame_swctl.sv
// Directed bench for qnet_frame_swctl. Expected window, trigger, busy, frame
// count and done timing come from a small cycle model indexed by k. k is the
// number of edges since the one that sampled go.
module tb_qnet_frame_swctl;

  localparam int CNT_W = 16;
  localparam int FRM_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             arm, abort, go;
  logic [CNT_W-1:0] cfg_period, cfg_sw_dly, cfg_sw_len;
  logic [FRM_W-1:0] cfg_num_frm;
  logic             sw_ctl, trig_out, busy, done;
  logic [FRM_W-1:0] frm_cnt;

  // This second instance has a narrow frame counter, for the continuous-wrap test.
  logic       arm2, go2, abort2;
  logic [5:0] num2;
  logic       sw2, trig2, busy2, done2;
  logic [5:0] frm2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  qnet_frame_swctl #(.CNT_W(CNT_W), .FRM_W(FRM_W), .TRIG_CYCS(8)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .go(go),
    .cfg_period(cfg_period), .cfg_sw_dly(cfg_sw_dly), .cfg_sw_len(cfg_sw_len),
    .cfg_num_frm(cfg_num_frm),
    .sw_ctl(sw_ctl), .trig_out(trig_out), .busy(busy), .frm_cnt(frm_cnt), .done(done)
  );

  qnet_frame_swctl #(.CNT_W(CNT_W), .FRM_W(6), .TRIG_CYCS(8)) dut_w (
    .clk(clk), .rst(rst), .arm(arm2), .abort(abort2), .go(go2),
    .cfg_period(cfg_period), .cfg_sw_dly(cfg_sw_dly), .cfg_sw_len(cfg_sw_len),
    .cfg_num_frm(num2),
    .sw_ctl(sw2), .trig_out(trig2), .busy(busy2), .frm_cnt(frm2), .done(done2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_arm(input int per, input int dly, input int len, input int num);
    cfg_period  = CNT_W'(per);
    cfg_sw_dly  = CNT_W'(dly);
    cfg_sw_len  = CNT_W'(len);
    cfg_num_frm = FRM_W'(num);
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_go();
    go = 1'b1;
    tick();
    go = 0;
  endtask

  // Compares n cycles, starting at k=0 (the go edge has already happened).
  // Leaves the bench at the observation point for k=n.
  task automatic observe(input int per, input int dly, input int len, input int nfr,
                         input int n, output int bad, output int sw_hi,
                         output int dcnt, output int dk);
    int wend, cyc, stop_k;
    logic e_sw, e_trig, e_busy, e_done;
    int   e_frm;
    wend   = (dly + len < per) ? dly + len : per;
    stop_k = per * nfr;
    bad = 0; sw_hi = 0; dcnt = 0; dk = -1;
    for (int k = 0; k < n; k++) begin
      cyc    = k % per;
      e_busy = (k < stop_k);
      e_sw   = e_busy && (cyc >= dly) && (cyc < wend);
      e_trig = e_busy && (cyc < 8);
      e_done = (k == stop_k);
      e_frm  = (k / per < nfr) ? k / per : nfr;
      if (sw_ctl !== e_sw || trig_out !== e_trig || busy !== e_busy ||
          done !== e_done || frm_cnt !== FRM_W'(e_frm)) bad++;
      if (sw_ctl === 1'b1) sw_hi++;
      if (done === 1'b1) begin
        dcnt++;
        dk = k;
      end
      tick();
    end
  endtask

  int bad, sw_hi, dcnt, dk;

  initial begin
    rst = 1'b1; arm = 0; abort = 0; go = 0;
    cfg_period = '0; cfg_sw_dly = '0; cfg_sw_len = '0; cfg_num_frm = '0;
    arm2 = 0; go2 = 0; abort2 = 0; num2 = '0;
    tick(); tick(); tick();
    check("rst_outputs", {27'd0, sw_ctl, trig_out, busy, done, |frm_cnt}, 32'd0);
    check("rst_outputs_w", {27'd0, sw2, trig2, busy2, done2, |frm2}, 32'd0);
    rst = 1'b0;
    tick();

    // go while IDLE is ignored.
    do_go();
    check("idle_go_busy", busy, 0);
    check("idle_go_trig", trig_out, 0);

    // Single frame: period 100, window 10..29, one frame.
    do_arm(100, 10, 20, 1);
    check("sf_busy_armed", busy, 1);
    check("sf_trig_armed", trig_out, 0);
    tick(); tick(); tick();
    do_go();
    observe(100, 10, 20, 1, 110, bad, sw_hi, dcnt, dk);
    check("sf_cycle_model", bad, 0);
    check("sf_sw_cycles", sw_hi, 20);
    check("sf_done_count", dcnt, 1);
    check("sf_done_k", dk, 100);
    check("sf_frm_final", frm_cnt, 1);

    // Multi-frame: full-frame window, 3 frames, so the switch stays high for 150 cycles.
    do_arm(50, 0, 50, 3);
    do_go();
    observe(50, 0, 50, 3, 160, bad, sw_hi, dcnt, dk);
    check("mf_cycle_model", bad, 0);
    check("mf_sw_cycles", sw_hi, 150);
    check("mf_done_count", dcnt, 1);
    check("mf_done_k", dk, 150);
    check("mf_frm_final", frm_cnt, 3);

    // Window clipped at the end of the frame: 10 cycles per frame.
    do_arm(100, 90, 30, 2);
    do_go();
    observe(100, 90, 30, 2, 205, bad, sw_hi, dcnt, dk);
    check("clip_cycle_model", bad, 0);
    check("clip_sw_cycles", sw_hi, 20);

    // Delay at the period: the switch never asserts.
    do_arm(100, 100, 20, 1);
    do_go();
    observe(100, 100, 20, 1, 105, bad, sw_hi, dcnt, dk);
    check("dly_eq_per_model", bad, 0);
    check("dly_eq_per_sw", sw_hi, 0);

    // Zero length: the switch never asserts.
    do_arm(100, 10, 0, 1);
    do_go();
    observe(100, 10, 0, 1, 105, bad, sw_hi, dcnt, dk);
    check("len0_model", bad, 0);
    check("len0_sw", sw_hi, 0);

    // Period 1 is clamped to 2. trig_out stays high while running.
    do_arm(1, 0, 1, 2);
    do_go();
    observe(2, 0, 1, 2, 8, bad, sw_hi, dcnt, dk);
    check("clamp_model", bad, 0);
    check("clamp_done_k", dk, 4);

    // Abort in frame 2 at cyc 15 of a 5-frame run.
    do_arm(40, 10, 20, 5);
    do_go();
    observe(40, 10, 20, 5, 55, bad, sw_hi, dcnt, dk);
    check("abort_pre_model", bad, 0);
    check("abort_pre_sw", sw_ctl, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_sw", sw_ctl, 0);
    check("abort_trig", trig_out, 0);
    check("abort_busy", busy, 0);
    check("abort_frm", frm_cnt, 1);
    dcnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1 || busy !== 1'b0) dcnt++;
      tick();
    end
    check("abort_quiet", dcnt, 0);

    // Abort together with go while ARMED: abort wins.
    do_arm(40, 10, 20, 1);
    abort = 1'b1; go = 1'b1;
    tick();
    abort = 1'b0; go = 1'b0;
    check("abort_go_busy", busy, 0);
    check("abort_go_trig", trig_out, 0);

    // Reset mid-run while the switch is on, then go without a new arm.
    do_arm(100, 10, 20, 0);
    do_go();
    observe(100, 10, 20, 1, 15, bad, sw_hi, dcnt, dk);
    check("rmr_pre_model", bad, 0);
    check("rmr_pre_sw", sw_ctl, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rmr_outputs", {27'd0, sw_ctl, trig_out, busy, done, |frm_cnt}, 32'd0);
    do_go();
    check("rmr_go_busy", busy, 0);
    check("rmr_go_sw_trig", {sw_ctl, trig_out}, 2'b00);

    // Continuous mode on the 6-bit instance: 67 frames of period 4 leave
    // frm_cnt at 67 mod 64 = 3. cfg_period changes mid-run and must not matter.
    cfg_period = 16'd4; cfg_sw_dly = 16'd1; cfg_sw_len = 16'd2; num2 = 6'd0;
    arm2 = 1'b1;
    tick();
    arm2 = 1'b0;
    go2 = 1'b1;
    tick();
    go2 = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 268; k++) begin
      if (k == 20) cfg_period = 16'd9;
      if (done2 === 1'b1) dcnt++;
      tick();
    end
    check("cont_frm_wrap", frm2, 3);
    check("cont_no_done", dcnt, 0);
    check("cont_busy", busy2, 1);
    check("cont_trig_frame_start", trig2, 1);
    abort2 = 1'b1;
    tick();
    abort2 = 1'b0;
    check("cont_abort_busy", busy2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
